// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int BE_W = 4;

    localparam logic [BE_W-1:0] BE_READ = 4'b0000;
    localparam logic [BE_W-1:0] BE_B0   = 4'b0001;
    localparam logic [BE_W-1:0] BE_B1   = 4'b0010;
    localparam logic [BE_W-1:0] BE_B2   = 4'b0100;
    localparam logic [BE_W-1:0] BE_B3   = 4'b1000;
    localparam logic [BE_W-1:0] BE_H0   = 4'b0011;
    localparam logic [BE_W-1:0] BE_H1   = 4'b1100;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Naturally aligned byte, half-word, word or read; anything else is rejected.
    function automatic logic be_legal(input logic [BE_W-1:0] be);
        return (be inside {BE_READ, BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_WORD});
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port data RAM, synchronous per-byte write and read.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [BE_W-1:0]                i_be,
    input  logic [31:0]                    i_wdata,
    output logic [31:0]                    o_rdata
);

    // One independent byte-wide memory per lane keeps each lane's write isolated.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (i_be[gi]) begin
                r_mem[i_addr] <= i_wdata[8*gi +: 8];
            end
            r_q <= r_mem[i_addr];
        end

        assign o_rdata[8*gi +: 8] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory port responder with programmable wait states.
//               Define DMEM_ERR_CHECK_EN to reject out-of-range/illegal-BE requests.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [BE_W-1:0] req_be_i,
    input  logic [31:0]     req_addr_i,
    input  logic [31:0]     req_wdata_i,
    output logic            rsp_valid_o,
    output logic [31:0]     rsp_rdata_o,
    output logic            rsp_err_o
);

    localparam int         c_AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e          r_state;
    state_e          w_state_nx;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nx;
    logic [c_AW-1:0] r_idx;
    logic [c_AW-1:0] w_idx;
    logic [c_AW-1:0] w_ram_idx;
    logic            r_load;
    logic            r_err;
    logic            w_accept;
    logic            w_err;
    logic [BE_W-1:0] w_ram_be;
    logic [31:0]     w_ram_rdata;
    logic            w_unused;

    assign req_ready_o = (r_state != ST_WAIT);
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_idx       = req_addr_i[c_AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign w_err    = (|req_addr_i[31:c_AW+2]) | ~be_legal(req_be_i);
    assign w_unused = &{1'b0, req_addr_i[1:0]};
`else
    assign w_err    = 1'b0;
    assign w_unused = &{1'b0, req_addr_i[1:0], req_addr_i[31:c_AW+2]};
`endif

    // The port follows the live request on an accept edge and the latched index
    // otherwise, so the RAM output register holds the load word on entry to RESP.
    assign w_ram_idx = w_accept ? w_idx : r_idx;
    assign w_ram_be  = (w_accept && !w_err) ? req_be_i : BE_READ;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_addr  (w_ram_idx),
        .i_be    (w_ram_be),
        .i_wdata (req_wdata_i),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nx = ST_RESP;
                    end else begin
                        w_state_nx = ST_WAIT;
                        w_cnt_nx   = c_CNT_LOAD;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nx = ST_RESP;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_load  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_accept) begin
                r_idx  <= w_idx;
                r_load <= (req_be_i == BE_READ);
                r_err  <= w_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= (r_state == ST_RESP);
            if (r_state == ST_RESP) begin
                rsp_rdata_o <= (r_load && !r_err) ? w_ram_rdata : '0;
                rsp_err_o   <= r_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench: one DUT with one wait state, one with none.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int c_DEPTH = 1024;
`ifdef DMEM_ERR_CHECK_EN
    localparam bit c_ERR_ON = 1'b1;
`else
    localparam bit c_ERR_ON = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic              clk;
    logic              rst;
    logic [1:0]        rv;
    logic [1:0][3:0]   rbe;
    logic [1:0][31:0]  raddr;
    logic [1:0][31:0]  rwd;
    wire  [1:0]        rdy;
    wire  [1:0]        vv;
    wire  [1:0]        er;
    wire  [1:0][31:0]  rd;

    int total = 0;
    int bad   = 0;

    // Reference model state, one slot per DUT (0: one wait state, 1: none)
    int          cyc[2];
    int          busy_until[2];
    int          p_due[2];
    logic        p_v[2];
    logic        p_er[2];
    logic [31:0] p_rd[2];
    logic        h_er[2];
    logic [31:0] h_rd[2];
    logic        exp_v[2];
    logic        exp_rdy[2];
    logic [31:0] mm[2][c_DEPTH];

    dmem_responder #(.DEPTH_WORDS(c_DEPTH), .WAIT_STATES(1)) u_dut_ws1 (
        .clk(clk), .rst(rst),
        .req_valid_i(rv[0]), .req_ready_o(rdy[0]), .req_be_i(rbe[0]),
        .req_addr_i(raddr[0]), .req_wdata_i(rwd[0]),
        .rsp_valid_o(vv[0]), .rsp_rdata_o(rd[0]), .rsp_err_o(er[0])
    );

    dmem_responder #(.DEPTH_WORDS(c_DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rst(rst),
        .req_valid_i(rv[1]), .req_ready_o(rdy[1]), .req_be_i(rbe[1]),
        .req_addr_i(raddr[1]), .req_wdata_i(rwd[1]),
        .rsp_valid_o(vv[1]), .rsp_rdata_o(rd[1]), .rsp_err_o(er[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %h, expected %h", nm, d, $time, act, exp);
        end
    endtask

    // Transaction-level model: an accepted request produces one response
    // WAIT_STATES+1 edges later and blocks new accepts for WAIT_STATES cycles.
    task automatic model_edge(input int d);
        int          idx;
        logic        e;
        logic [31:0] a;
        cyc[d]++;
        exp_v[d] = 1'b0;
        if (rst) begin
            p_v[d]        = 1'b0;
            h_rd[d]       = 32'h0;
            h_er[d]       = 1'b0;
            busy_until[d] = cyc[d];
        end else begin
            if (p_v[d] && p_due[d] == cyc[d]) begin
                exp_v[d] = 1'b1;
                h_rd[d]  = p_rd[d];
                h_er[d]  = p_er[d];
                p_v[d]   = 1'b0;
            end
            if (rv[d] && exp_rdy[d]) begin
                a   = raddr[d];
                idx = int'((a >> 2) % c_DEPTH);
                e   = c_ERR_ON && ((a >= 32'(c_DEPTH * 4)) ||
                      !(rbe[d] inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                       4'b1000, 4'b0011, 4'b1100, 4'b1111}));
                p_rd[d] = (rbe[d] == 4'b0000 && !e) ? mm[d][idx] : 32'h0;
                if (!e) begin
                    for (int b = 0; b < 4; b++) begin
                        if (rbe[d][b]) mm[d][idx][8*b +: 8] = rwd[d][8*b +: 8];
                    end
                end
                p_er[d]       = e;
                p_v[d]        = 1'b1;
                p_due[d]      = cyc[d] + ws_of(d) + 1;
                busy_until[d] = cyc[d] + ws_of(d);
            end
        end
        exp_rdy[d] = (cyc[d] >= busy_until[d]);
        #1;
        check("rsp_valid", d, 32'(vv[d]), 32'(exp_v[d]));
        check("rsp_rdata", d, rd[d], h_rd[d]);
        check("rsp_err", d, 32'(er[d]), 32'(h_er[d]));
        check("req_ready", d, 32'(rdy[d]), 32'(exp_rdy[d]));
    endtask

    always @(posedge clk) model_edge(0);
    always @(posedge clk) model_edge(1);

    // Presents a request from a negedge and returns just after its accept edge.
    task automatic issue(input int d, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        rv[d] = 1'b1; rbe[d] = be; raddr[d] = a; rwd[d] = wd;
        for (n = 0; n < 40; n++) begin
            if (rdy[d]) break;
            @(negedge clk);
        end
        if (n == 40) begin
            total++; bad++;
            $display("FAIL issue_timeout dut%0d: ready stayed 0, expected 1", d);
        end
        @(posedge clk);
    endtask

    task automatic wait_rsp(input int d, output int lat);
        int k;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) rv[d] = 1'b0;
            if (vv[d]) break;
        end
        lat = k - 1;
        if (k > 20) begin
            total++; bad++;
            $display("FAIL rsp_timeout dut%0d: rsp_valid stayed 0, expected 1", d);
        end
    endtask

    initial begin
        vec_t        tv[9];
        logic [3:0]  legal_be[8];
        int          lat;
        int          lows;
        int          vcnt;
        logic [31:0] old_w;
        logic [31:0] new_w;
        logic [3:0]  be;
        logic [31:0] addr;

        rst = 1'b1; rv = '0; rbe = '0; raddr = '0; rwd = '0;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 0; busy_until[d] = 0; p_due[d] = 0; p_v[d] = 1'b0; p_er[d] = 1'b0;
            p_rd[d] = '0; h_er[d] = 1'b0; h_rd[d] = '0; exp_v[d] = 1'b0; exp_rdy[d] = 1'b1;
        end
        legal_be = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

        tv[0] = '{4'hF, 32'h10,   32'hDEADBEEF, 32'h0, 1'b0};
        tv[1] = '{4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        tv[2] = '{4'h4, 32'h12,   32'h00AA0000, 32'h0, 1'b0};
        tv[3] = '{4'h0, 32'h10,   32'h0,        32'hDEAABEEF, 1'b0};
        tv[4] = '{4'hF, 32'h0,    32'h11223344, 32'h0, 1'b0};
        tv[5] = '{4'hF, 32'h1000, 32'h55667788, 32'h0, c_ERR_ON};
        tv[6] = '{4'h0, 32'h0,    32'h0, c_ERR_ON ? 32'h11223344 : 32'h55667788, 1'b0};
        tv[7] = '{4'h5, 32'h0,    32'hAABBCCDD, 32'h0, c_ERR_ON};
        tv[8] = '{4'h0, 32'h0,    32'h0, c_ERR_ON ? 32'h11223344 : 32'h55BB77DD, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed vectors on the one-wait-state DUT
        for (int i = 0; i < 9; i++) begin
            issue(0, tv[i].be, tv[i].addr, tv[i].wdata);
            wait_rsp(0, lat);
            check($sformatf("tv%0d_latency", i), 0, 32'(lat), 32'd2);
            check($sformatf("tv%0d_rdata", i), 0, rd[0], tv[i].exp_rdata);
            check($sformatf("tv%0d_err", i), 0, 32'(er[0]), 32'(tv[i].exp_err));
        end

        // Fill the words used below so every later load has a known value
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) issue(d, 4'hF, 32'(w * 4), $urandom | 32'h1);
            @(negedge clk);
            rv[d] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Zero wait states, valid held high: an accept and a response every cycle
        lows = 0; vcnt = 0;
        @(negedge clk);
        rv[1] = 1'b1; rbe[1] = 4'h0; raddr[1] = 32'h0;
        for (int i = 0; i < 12; i++) begin
            if (!rdy[1]) lows++;
            if (vv[1]) vcnt++;
            @(negedge clk);
            raddr[1] = raddr[1] ^ 32'h4;
        end
        rv[1] = 1'b0;
        check("tput_ready_low_cycles", 1, 32'(lows), 32'd0);
        check("tput_responses", 1, 32'(vcnt), 32'd10);
        repeat (3) @(negedge clk);

        // Reset during the WAIT cycle of a load drops it
        issue(0, 4'h0, 32'h4, 32'h0);
        wait_rsp(0, lat);
        issue(0, 4'h0, 32'h20, 32'h0);
        @(negedge clk);
        rv[0] = 1'b0;
        rst   = 1'b1;
        #1;
        check("rst_valid", 0, 32'(vv[0]), 32'd0);
        check("rst_rdata", 0, rd[0], 32'h0);
        check("rst_err", 0, 32'(er[0]), 32'd0);
        check("rst_ready", 0, 32'(rdy[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        issue(0, 4'h0, 32'h20, 32'h0);
        wait_rsp(0, lat);
        check("post_rst_latency", 0, 32'(lat), 32'd2);
        check("post_rst_rdata", 0, rd[0], mm[0][8]);

        // Store to the same word accepted in the RESP cycle of a load
        repeat (3) @(negedge clk);
        old_w = mm[0][8];
        new_w = old_w ^ 32'h5A5A0F0F;
        issue(0, 4'h0, 32'h20, 32'h0);
        issue(0, 4'hF, 32'h20, new_w);
        wait_rsp(0, lat);
        check("raw_old_rdata", 0, rd[0], old_w);
        repeat (3) @(negedge clk);
        issue(0, 4'h0, 32'h20, 32'h0);
        wait_rsp(0, lat);
        check("raw_new_rdata", 0, rd[0], new_w);
        repeat (3) @(negedge clk);

        // Random traffic, checked every cycle by the model
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: be = 4'h0;
                    5, 6, 7:       be = legal_be[$urandom_range(0, 7)];
                    default:       be = 4'($urandom);
                endcase
                addr = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 9) >= 8) addr = addr + 32'h1000;
                issue(d, be, addr, $urandom);
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    rv[d] = 1'b0;
                end
            end
            @(negedge clk);
            rv[d] = 1'b0;
            repeat (4) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
